// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: drains the registered read port into a
// 3-entry buffer and presents it as a valid/ready stream with burst framing.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic                               fifo_empty,
    output logic                               fifo_r_en,
    input  logic [DATA_WIDTH-1:0]              fifo_rdata,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [DATA_WIDTH-1:0]              m_data,
    output logic                               m_last,
    output logic [$clog2(BURST_LEN + 1)-1:0]   beat_cnt,
    output logic [15:0]                        word_count,
    output logic                               idle
);

    localparam int unsigned BeatW = $clog2(BURST_LEN + 1);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] mem_q [3];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_pending_q;
    logic [BeatW-1:0]      beat_q, beat_d;
    logic [15:0]           word_count_q, word_count_d;
    logic [2:0]            occupancy;
    logic                  capture;
    logic                  handshake;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // In-flight read reserves a slot, so a capture always finds room.
    assign occupancy = {1'b0, count_q} + {2'b00, rd_pending_q};
    assign fifo_r_en = rst_n & enable & ~fifo_empty & (occupancy < 3'd3);

    assign capture    = rd_pending_q;
    assign m_valid    = (count_q != 2'd0);
    assign handshake  = m_valid & m_ready;
    assign m_last     = m_valid & (beat_q == LastBeat);
    assign beat_cnt   = beat_q;
    assign word_count = word_count_q;
    assign idle       = (count_q == 2'd0) & ~rd_pending_q;

    always_comb begin
        m_data = mem_q[0];
        if (rd_ptr_q == 2'd1) begin
            m_data = mem_q[1];
        end else if (rd_ptr_q == 2'd2) begin
            m_data = mem_q[2];
        end
    end

    always_comb begin
        wr_ptr_d     = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = handshake ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d      = count_q;
        unique case ({capture, handshake})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        beat_d       = beat_q;
        if (handshake) begin
            beat_d = m_last ? '0 : beat_q + BeatW'(1);
        end
        word_count_d = word_count_q + 16'(handshake);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 2'd0;
            rd_pending_q <= 1'b0;
            beat_q       <= '0;
            word_count_q <= 16'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_pending_q <= fifo_r_en;
            beat_q       <= beat_d;
            word_count_q <= word_count_d;
        end
    end

    // Data storage needs no reset; m_data is only meaningful while m_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && capture && (wr_ptr_q == 2'(i))) begin
                mem_q[i] <= fifo_rdata;
            end
        end
    end

endmodule
